// File: rtl/vga_vram_arbiter.sv
// VRAM port arbiter: VGA scan-out prefetch has priority, CPU fills idle slots.
// One packed pixel word is fetched one word ahead of the beam and shifted out.
module vga_vram_arbiter #(
  parameter int H_DISP  = 640,
  parameter int V_DISP  = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int PPW     = 8,
  parameter int BPP     = 4,
  parameter int AW      = 16,
  parameter int DW      = PPW * BPP
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           p_tick,
  input  logic           video_on,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_ack,
  output logic           vram_en,
  output logic           vram_we,
  output logic [AW-1:0]  vram_addr,
  output logic [DW-1:0]  vram_wdata,
  input  logic [DW-1:0]  vram_rdata,
  output logic [BPP-1:0] pix_color,
  output logic           underrun
);

  localparam int PB = $clog2(PPW);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VFETCH = 3'd1;
  localparam logic [2:0] S_VCAPT  = 3'd2;
  localparam logic [2:0] S_CPU    = 3'd3;
  localparam logic [2:0] S_CDONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic           pend_q, pend_d;
  logic           under_q, under_d;
  logic [AW-1:0]  faddr_q, faddr_d;
  logic [DW-1:0]  pref_q, pref_d;
  logic [DW-1:0]  shift_q, shift_d;
  logic [BPP-1:0] pix_q, pix_d;

  logic           bound;
  logic           fire;
  logic [10:0]    tx_raw;
  logic [10:0]    tx;
  logic [9:0]     ty;
  logic [AW-1:0]  taddr;

  // Target is the word one PPW ahead, wrapping into the next line/frame.
  always_comb begin
    bound  = p_tick && (pixel_x[PB-1:0] == '0);
    tx_raw = {1'b0, pixel_x} + 11'(PPW);
    if (tx_raw >= 11'(H_TOTAL)) begin
      tx = tx_raw - 11'(H_TOTAL);
      ty = (pixel_y == 10'(V_TOTAL - 1)) ? '0 : pixel_y + 10'd1;
    end else begin
      tx = tx_raw;
      ty = pixel_y;
    end
    fire  = bound && (tx < 11'(H_DISP)) && (ty < 10'(V_DISP));
    taddr = AW'(ty) * AW'(H_DISP / PPW) + AW'(tx >> PB);
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    under_d = under_q;
    faddr_d = faddr_q;
    pref_d  = pref_q;
    if (fire) begin
      pend_d  = 1'b1;
      faddr_d = taddr;
      if (pend_q) under_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        // A trigger in this very cycle already beats a waiting CPU.
        if (pend_q || fire) state_d = S_VFETCH;
        else if (cpu_req)   state_d = S_CPU;
      end
      S_VFETCH: state_d = S_VCAPT;
      S_VCAPT: begin
        pref_d  = vram_rdata;
        if (!fire) pend_d = 1'b0;
        state_d = S_IDLE;
      end
      S_CPU:   state_d = S_CDONE;
      S_CDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    pix_d   = pix_q;
    if (p_tick) begin
      shift_d = bound ? pref_q : (shift_q >> BPP);
      pix_d   = video_on ? shift_d[BPP-1:0] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      under_q <= 1'b0;
      faddr_q <= '0;
      pref_q  <= '0;
      shift_q <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      under_q <= under_d;
      faddr_q <= faddr_d;
      pref_q  <= pref_d;
      shift_q <= shift_d;
      pix_q   <= pix_d;
    end
  end

  logic cpu_slot;
  assign cpu_slot   = (state_q == S_CPU);
  assign vram_en    = cpu_slot || (state_q == S_VFETCH);
  assign vram_we    = cpu_slot && cpu_we;
  assign vram_addr  = (state_q == S_VFETCH) ? faddr_q :
                      cpu_slot ? cpu_addr : '0;
  assign vram_wdata = (cpu_slot && cpu_we) ? cpu_wdata : '0;
  assign cpu_ack    = (state_q == S_CDONE);
  assign cpu_rdata  = cpu_ack ? vram_rdata : '0;
  assign pix_color  = pix_q;
  assign underrun   = under_q;

endmodule
